// File: rtl/md_unit.sv
// md_unit: iterative-latency HI/LO multiply/divide unit for the execute stage.
// Optional multiply-accumulate ops (madd/msub) are built when MD_MADD_EN is defined.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MD_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;

  logic        accept, long_op, done;
  logic [3:0]  lim;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b, q_mag, r_mag;
  logic [31:0] quo, rem;
  logic        res_wr;
  logic [31:0] res_hi, res_lo;

  assign accept = start && (state == IDLE);
  assign busy   = (state == RUN);

  // Decode which accepted ops occupy the unit for several cycles
  always_comb begin
    long_op = 1'b0;
    if (accept) begin
      unique case (1'b1)
        (mdop == OP_MULT),
        (mdop == OP_MULTU),
        (mdop == OP_DIV),
        (mdop == OP_DIVU): long_op = 1'b1;
`ifdef MD_MADD_EN
        (mdop == OP_MADD),
        (mdop == OP_MSUB): long_op = 1'b1;
`endif
        default: long_op = 1'b0;
      endcase
    end
  end

  assign lim  = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? DIV_N : MULT_N;
  assign done = (state == RUN) && (cnt == lim);

  // FSM and cycle counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: count busy cycles, leave RUN on the commit edge
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (long_op) begin
          state_n = RUN;
          cnt_n   = 4'd1;
        end
      end
      RUN: begin
        if (done) begin
          state_n = IDLE;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  // Capture operands and opcode at the accepting edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= 3'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
    end else if (long_op) begin
      op_q <= mdop;
      a_q  <= src_a;
      b_q  <= src_b;
    end
  end

  // Result datapath; divide works on magnitudes so INT_MIN/-1 wraps cleanly
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    a_neg  = (op_q == OP_DIV) && a_q[31];
    b_neg  = (op_q == OP_DIV) && b_q[31];
    mag_a  = a_neg ? (~a_q + 32'd1) : a_q;
    mag_b  = b_neg ? (~b_q + 32'd1) : b_q;
    q_mag  = 32'd0;
    r_mag  = 32'd0;
    if (b_q != 32'd0) begin
      q_mag = mag_a / mag_b;
      r_mag = mag_a % mag_b;
    end
    quo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem = a_neg ? (~r_mag + 32'd1) : r_mag;

    res_wr = 1'b0;
    res_hi = hi;
    res_lo = lo;
    unique case (1'b1)
      (op_q == OP_MULT): begin
        res_wr = 1'b1;
        {res_hi, res_lo} = prod_s;
      end
      (op_q == OP_MULTU): begin
        res_wr = 1'b1;
        {res_hi, res_lo} = prod_u;
      end
      (op_q == OP_DIV),
      (op_q == OP_DIVU): begin
        res_wr = (b_q != 32'd0);
        res_hi = rem;
        res_lo = quo;
      end
`ifdef MD_MADD_EN
      (op_q == OP_MADD): begin
        res_wr = 1'b1;
        {res_hi, res_lo} = {hi, lo} + prod_s;
      end
      (op_q == OP_MSUB): begin
        res_wr = 1'b1;
        {res_hi, res_lo} = {hi, lo} - prod_s;
      end
`endif
      default: res_wr = 1'b0;
    endcase
  end

  // HI/LO: moves write at accept, long ops write at commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (done) begin
      if (res_wr) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else if (accept && (mdop == OP_MTHI)) begin
      hi <= src_a;
    end else if (accept && (mdop == OP_MTLO)) begin
      lo <= src_a;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized and directed checks of md_unit
// against a 64-bit arithmetic reference model.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] src_a, src_b;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          m_cyc;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop),
    .src_a(src_a), .src_b(src_b),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Architectural behaviour of one accepted op
  function automatic void model(input logic [2:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p, acc, q64, r64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_cyc = 0;
    case (op)
      3'd0: begin
        p = 64'(sa * sb);
        {m_hi, m_lo} = p;
        m_cyc = MC;
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        {m_hi, m_lo} = p;
        m_cyc = MC;
      end
      3'd2: begin
        m_cyc = DC;
        if (b != 0) begin
          sq = sa / sb;
          sr = sa % sb;
          q64 = 64'(sq);
          r64 = 64'(sr);
          m_lo = q64[31:0];
          m_hi = r64[31:0];
        end
      end
      3'd3: begin
        m_cyc = DC;
        if (b != 0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: begin
`ifdef MD_MADD_EN
        p = 64'(sa * sb);
        acc = {m_hi, m_lo};
        acc = (op == 3'd6) ? acc + p : acc - p;
        {m_hi, m_lo} = acc;
        m_cyc = MC;
`else
        acc = 64'd0;
        p = acc;
`endif
      end
    endcase
  endfunction

  // Issue one op, count busy cycles, watch hi/lo stay at model values
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int cyc,
                        output bit held);
    @(negedge clk);
    start = 1'b1;
    mdop  = op;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    cyc = 0;
    held = 1'b1;
    while (busy && cyc < 40) begin
      if (hi !== m_hi || lo !== m_lo) held = 1'b0;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    mdop  = 3'd0;
    src_a = 32'd0;
    src_b = 32'd0;
    #12;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_state busy=%b hi=%h lo=%h want 0/0/0",
               busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mult();
    int cyc;
    bit held;
    logic [2:0] ops [2] = '{3'd0, 3'd1};
    foreach (ops[i]) begin
      run_op(ops[i], 32'hFFFFFFFF, 32'd2, cyc, held);
      checks++;
      if (!held) begin
        failures++;
        $display("FAIL mult_hold op=%0d hi/lo changed while busy", ops[i]);
      end
      model(ops[i], 32'hFFFFFFFF, 32'd2);
      checks++;
      if (cyc !== m_cyc) begin
        failures++;
        $display("FAIL mult_cycles op=%0d got=%0d want=%0d",
                 ops[i], cyc, m_cyc);
      end
      checks++;
      if (hi !== m_hi || lo !== m_lo) begin
        failures++;
        $display("FAIL mult_result op=%0d got=%h_%h want=%h_%h",
                 ops[i], hi, lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_div();
    int cyc;
    bit held;
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, cyc, held);
    model(3'd2, 32'hFFFFFFF9, 32'd2);
    checks++;
    if (cyc !== m_cyc || hi !== m_hi || lo !== m_lo) begin
      failures++;
      $display("FAIL div_neg cyc=%0d hi=%h lo=%h want %0d %h %h",
               cyc, hi, lo, m_cyc, m_hi, m_lo);
    end
    run_op(3'd3, 32'd7, 32'd0, cyc, held);
    model(3'd3, 32'd7, 32'd0);
    checks++;
    if (cyc !== m_cyc || !held || hi !== m_hi || lo !== m_lo) begin
      failures++;
      $display("FAIL divu_zero cyc=%0d held=%0d hi=%h lo=%h want %0d 1 %h %h",
               cyc, held, hi, lo, m_cyc, m_hi, m_lo);
    end
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, cyc, held);
    model(3'd2, 32'h80000000, 32'hFFFFFFFF);
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      failures++;
      $display("FAIL div_ovf hi=%h lo=%h want %h %h", hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_moves();
    @(negedge clk);
    start = 1'b1;
    mdop  = 3'd4;
    src_a = 32'h12345678;
    @(negedge clk);
    model(3'd4, 32'h12345678, 32'd0);
    checks++;
    if (hi !== m_hi || busy !== 1'b0) begin
      failures++;
      $display("FAIL mthi hi=%h busy=%b want %h 0", hi, busy, m_hi);
    end
    mdop  = 3'd5;
    src_a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    model(3'd5, 32'h9ABCDEF0, 32'd0);
    checks++;
    if (lo !== m_lo || hi !== m_hi || busy !== 1'b0) begin
      failures++;
      $display("FAIL mtlo hi=%h lo=%h busy=%b want %h %h 0",
               hi, lo, busy, m_hi, m_lo);
    end
  endtask

  task automatic test_ignore();
    int cyc;
    @(negedge clk);
    start = 1'b1;
    mdop  = 3'd2;
    src_a = 32'd100;
    src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      if (cyc == 3) begin
        start = 1'b1;
        mdop  = 3'd0;
        src_a = 32'd5;
      end else begin
        start = 1'b0;
        src_a = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    model(3'd2, 32'd100, 32'd7);
    checks++;
    if (cyc !== m_cyc || hi !== m_hi || lo !== m_lo) begin
      failures++;
      $display("FAIL ignore_busy cyc=%0d hi=%h lo=%h want %0d %h %h",
               cyc, hi, lo, m_cyc, m_hi, m_lo);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_after busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit held;
    @(negedge clk);
    start = 1'b1;
    mdop  = 3'd0;
    src_a = 32'd3;
    src_b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid busy=%b hi=%h lo=%h want 0/0/0",
               busy, hi, lo);
    end
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    run_op(3'd0, 32'h00001234, 32'hFFFFFFF0, cyc, held);
    model(3'd0, 32'h00001234, 32'hFFFFFFF0);
    checks++;
    if (cyc !== m_cyc || hi !== m_hi || lo !== m_lo) begin
      failures++;
      $display("FAIL after_reset cyc=%0d hi=%h lo=%h want %0d %h %h",
               cyc, hi, lo, m_cyc, m_hi, m_lo);
    end
  endtask

  task automatic test_madd();
    int cyc;
    bit held;
    run_op(3'd4, 32'd0, 32'd0, cyc, held);
    model(3'd4, 32'd0, 32'd0);
    run_op(3'd5, 32'hFFFFFFFF, 32'd0, cyc, held);
    model(3'd5, 32'hFFFFFFFF, 32'd0);
    run_op(3'd6, 32'd1, 32'd1, cyc, held);
    model(3'd6, 32'd1, 32'd1);
    checks++;
    if (cyc !== m_cyc || hi !== m_hi || lo !== m_lo) begin
      failures++;
      $display("FAIL madd cyc=%0d hi=%h lo=%h want %0d %h %h",
               cyc, hi, lo, m_cyc, m_hi, m_lo);
    end
    run_op(3'd7, 32'd3, 32'hFFFFFFFE, cyc, held);
    model(3'd7, 32'd3, 32'hFFFFFFFE);
    checks++;
    if (cyc !== m_cyc || hi !== m_hi || lo !== m_lo) begin
      failures++;
      $display("FAIL msub cyc=%0d hi=%h lo=%h want %0d %h %h",
               cyc, hi, lo, m_cyc, m_hi, m_lo);
    end
  endtask

  task automatic test_random();
    int cyc;
    bit held;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(op, a, b, cyc, held);
      checks++;
      if (!held) begin
        failures++;
        $display("FAIL rand_hold n=%0d op=%0d", n, op);
      end
      model(op, a, b);
      checks++;
      if (cyc !== m_cyc || hi !== m_hi || lo !== m_lo) begin
        failures++;
        $display("FAIL rand n=%0d op=%0d a=%h b=%h cyc=%0d hi=%h lo=%h want %0d %h %h",
                 n, op, a, b, cyc, hi, lo, m_cyc, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_moves();
    test_ignore();
    test_reset_mid();
    test_madd();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
